// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: opcodes, access sizes,
// FSM states, trap causes and the store-side lane helpers.
package mem_stage_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [1:0] LDSZ_BYTE = 2'b00;
    localparam logic [1:0] LDSZ_HALF = 2'b01;
    localparam logic [1:0] LDSZ_WORD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_WAIT_R = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    typedef enum logic {
        CAUSE_MISALIGN    = 1'b0,
        CAUSE_BUS_TIMEOUT = 1'b1
    } trap_cause_t;

    // Byte lanes touched by an access of the given size at the given offset.
    function automatic logic [3:0] byteEnables(input logic [1:0] ldsz, input logic [1:0] shift);
        logic [3:0] be;
        case (ldsz)
            LDSZ_BYTE: be = 4'b0001 << shift;
            LDSZ_HALF: be = 4'b0011 << shift;
            default:   be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate store data across the word so every lane carries the operand.
    function automatic logic [31:0] storeData(input logic [1:0] ldsz, input logic [31:0] d);
        logic [31:0] w;
        case (ldsz)
            LDSZ_BYTE: w = {4{d[7:0]}};
            LDSZ_HALF: w = {2{d[15:0]}};
            default:   w = d;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory bus between the memory stage (master) and memory (slave),
// using a req/gnt request phase and an rvalid response phase.
interface mem_stage_if;

    logic        dmem_req;
    logic        dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );

endinterface

// File: rtl/mem_stage_load_align.sv
// Moves the addressed byte/half of a read word down to bit 0 and
// zero- or sign-extends it to 32 bits.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_ldsz,
    input  logic [1:0]  i_ldshift,
    input  logic        i_ldunsigned,
    output logic [31:0] o_data
);

    logic [31:0] w_shifted;

    assign w_shifted = i_rdata >> {i_ldshift, 3'b000};

    // Extend the selected lane according to the access size and signedness
    always_comb begin
        o_data = w_shifted;
        case (i_ldsz)
            LDSZ_BYTE: o_data = i_ldunsigned ? {24'd0, w_shifted[7:0]}
                                             : {{24{w_shifted[7]}}, w_shifted[7:0]};
            LDSZ_HALF: o_data = i_ldunsigned ? {16'd0, w_shifted[15:0]}
                                             : {{16{w_shifted[15]}}, w_shifted[15:0]};
            default:   o_data = w_shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: registers the EX result, runs loads/stores on the
// data bus, forwards results to EX and retires instructions to writeback.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               ext_stall,
    input  logic               ex_valid,
    input  logic [6:0]         ex_opcode,
    input  logic [4:0]         ex_rd,
    input  logic [31:0]        ex_res,
    input  logic [31:0]        ex_store_data,
    input  logic [1:0]         ex_ldsz,
    input  logic [1:0]         ex_ldshift,
    input  logic               ex_ldunsigned,
    input  logic               ex_trap,
    output logic               ex_ready,
    mem_stage_if.master        dmem,
    output logic [4:0]         rd_MEM,
    output logic [31:0]        res_MEM,
    output logic               wb_valid,
    output logic [4:0]         wb_rd,
    output logic [31:0]        wb_res,
    output logic               stall_req,
    output logic               trap_MEM,
    output logic               trap_cause
);

    state_t      r_state;
    logic [4:0]  r_rd;
    logic [31:0] r_res;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic        r_isStore;
    logic        r_trap;
    logic [1:0]  r_ldsz;
    logic [1:0]  r_ldshift;
    logic        r_ldunsigned;
    logic [31:0] r_cnt;
    logic        r_gntSeen;
    logic        r_rvalidSeen;
    logic [31:0] r_rdataSeen;
    logic        r_trapMem;
    trap_cause_t r_trapCause;

    logic        w_gnt;
    logic        w_rvalid;
    logic [31:0] w_rdata;
    logic [31:0] w_loadData;
    logic        w_capture;
    logic        w_exMem;
    logic        w_timeout;
    logic        w_retire;

    // A handshake seen while frozen is held until the freeze lifts
    assign w_gnt    = dmem.dmem_gnt | r_gntSeen;
    assign w_rvalid = dmem.dmem_rvalid | r_rvalidSeen;
    assign w_rdata  = r_rvalidSeen ? r_rdataSeen : dmem.dmem_rdata;

    assign ex_ready  = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_capture = ex_valid && ex_ready && !ext_stall;
    assign w_exMem   = (ex_opcode == OPC_LOAD) || (ex_opcode == OPC_STORE);
    assign w_timeout = (BUS_TIMEOUT != 0) && (r_cnt == 32'(BUS_TIMEOUT - 1));

    load_align u_loadAlign (
        .i_rdata      (w_rdata),
        .i_ldsz       (r_ldsz),
        .i_ldshift    (r_ldshift),
        .i_ldunsigned (r_ldunsigned),
        .o_data       (w_loadData)
    );

    // Pipeline register, bus-transaction FSM and timeout counter
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_rd         <= 5'd0;
            r_res        <= 32'd0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_be         <= 4'd0;
            r_isStore    <= 1'b0;
            r_trap       <= 1'b0;
            r_ldsz       <= 2'd0;
            r_ldshift    <= 2'd0;
            r_ldunsigned <= 1'b0;
            r_cnt        <= 32'd0;
            r_gntSeen    <= 1'b0;
            r_rvalidSeen <= 1'b0;
            r_rdataSeen  <= 32'd0;
            r_trapMem    <= 1'b0;
            r_trapCause  <= CAUSE_MISALIGN;
        end else if (ext_stall) begin
            if (r_state == ST_REQ && dmem.dmem_gnt)
                r_gntSeen <= 1'b1;
            if ((r_state == ST_REQ || r_state == ST_WAIT_R) && dmem.dmem_rvalid) begin
                r_rvalidSeen <= 1'b1;
                r_rdataSeen  <= dmem.dmem_rdata;
            end
        end else begin
            r_trapMem   <= 1'b0;
            r_trapCause <= CAUSE_MISALIGN;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_capture) begin
                        r_rd         <= ex_rd;
                        r_res        <= ex_res;
                        r_addr       <= ex_res;
                        r_wdata      <= storeData(ex_ldsz, ex_store_data);
                        r_be         <= byteEnables(ex_ldsz, ex_ldshift);
                        r_isStore    <= (ex_opcode == OPC_STORE);
                        r_trap       <= ex_trap;
                        r_ldsz       <= ex_ldsz;
                        r_ldshift    <= ex_ldshift;
                        r_ldunsigned <= ex_ldunsigned;
                        r_cnt        <= 32'd0;
                        if (ex_trap) begin
                            r_state     <= ST_DONE;
                            r_trapMem   <= 1'b1;
                            r_trapCause <= CAUSE_MISALIGN;
                        end else if (w_exMem) begin
                            r_state <= ST_REQ;
                        end else begin
                            r_state <= ST_DONE;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (w_gnt) begin
                        r_gntSeen    <= 1'b0;
                        r_rvalidSeen <= 1'b0;
                        r_cnt        <= 32'd0;
                        if (r_isStore) begin
                            r_state <= ST_DONE;
                        end else if (w_rvalid) begin
                            r_res   <= w_loadData;
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_WAIT_R;
                        end
                    end else if (w_timeout) begin
                        r_state      <= ST_IDLE;
                        r_cnt        <= 32'd0;
                        r_rvalidSeen <= 1'b0;
                        r_trapMem    <= 1'b1;
                        r_trapCause  <= CAUSE_BUS_TIMEOUT;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                ST_WAIT_R: begin
                    if (w_rvalid) begin
                        r_res        <= w_loadData;
                        r_rvalidSeen <= 1'b0;
                        r_cnt        <= 32'd0;
                        r_state      <= ST_DONE;
                    end else if (w_timeout) begin
                        r_state     <= ST_IDLE;
                        r_cnt       <= 32'd0;
                        r_trapMem   <= 1'b1;
                        r_trapCause <= CAUSE_BUS_TIMEOUT;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign dmem.dmem_req   = (r_state == ST_REQ);
    assign dmem.dmem_we    = r_isStore;
    assign dmem.dmem_be    = r_be;
    assign dmem.dmem_addr  = r_addr;
    assign dmem.dmem_wdata = r_wdata;

    // Loads only expose rd once data has landed; stores and traps never do
    assign w_retire  = (r_state == ST_DONE) && !r_trap && !r_isStore;
    assign rd_MEM    = w_retire ? r_rd : 5'd0;
    assign res_MEM   = r_res;
    assign wb_valid  = w_retire && (r_rd != 5'd0);
    assign wb_rd     = r_rd;
    assign wb_res    = r_res;
    assign stall_req = (r_state == ST_REQ) || (r_state == ST_WAIT_R);
    assign trap_MEM  = r_trapMem;
    assign trap_cause = r_trapCause;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed instructions, a behavioural
// bus responder and a retirement scoreboard fed at issue time.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int TIMEOUT = 4;
    localparam logic [6:0] OPC_ADD = 7'b0110011;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ext_stall;
    logic        ex_valid;
    logic [6:0]  ex_opcode;
    logic [4:0]  ex_rd;
    logic [31:0] ex_res;
    logic [31:0] ex_store_data;
    logic [1:0]  ex_ldsz;
    logic [1:0]  ex_ldshift;
    logic        ex_ldunsigned;
    logic        ex_trap;
    logic        ex_ready;
    logic [4:0]  rd_MEM;
    logic [31:0] res_MEM;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_res;
    logic        stall_req;
    logic        trap_MEM;
    logic        trap_cause;

    mem_stage_if dmemBus ();

    mem_stage #(.BUS_TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .ext_stall     (ext_stall),
        .ex_valid      (ex_valid),
        .ex_opcode     (ex_opcode),
        .ex_rd         (ex_rd),
        .ex_res        (ex_res),
        .ex_store_data (ex_store_data),
        .ex_ldsz       (ex_ldsz),
        .ex_ldshift    (ex_ldshift),
        .ex_ldunsigned (ex_ldunsigned),
        .ex_trap       (ex_trap),
        .ex_ready      (ex_ready),
        .dmem          (dmemBus),
        .rd_MEM        (rd_MEM),
        .res_MEM       (res_MEM),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .wb_res        (wb_res),
        .stall_req     (stall_req),
        .trap_MEM      (trap_MEM),
        .trap_cause    (trap_cause)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        isTrap;
        logic        cause;
        logic [4:0]  rd;
        logic [31:0] res;
    } exp_t;

    exp_t expQ[$];
    exp_t monE;
    int   errors = 0;
    int   checks = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
    endtask

    task automatic pushWb(input logic [4:0] rd, input logic [31:0] res);
        exp_t e;
        e.isTrap = 1'b0;
        e.cause  = 1'b0;
        e.rd     = rd;
        e.res    = res;
        expQ.push_back(e);
    endtask

    task automatic pushTrap(input logic cause);
        exp_t e;
        e.isTrap = 1'b1;
        e.cause  = cause;
        e.rd     = 5'd0;
        e.res    = 32'd0;
        expQ.push_back(e);
    endtask

    // Present one EX instruction and return at the negedge after it is captured
    task automatic applyStimulus(input logic [6:0] opc, input logic [4:0] rd, input logic [31:0] res,
                                 input logic [31:0] sdata, input logic [1:0] sz, input logic [1:0] sh,
                                 input logic uns, input logic trap);
        int n;
        ex_opcode     = opc;
        ex_rd         = rd;
        ex_res        = res;
        ex_store_data = sdata;
        ex_ldsz       = sz;
        ex_ldshift    = sh;
        ex_ldunsigned = uns;
        ex_trap       = trap;
        ex_valid      = 1'b1;
        n = 0;
        while (!ex_ready && n < 50) begin
            cycle();
            n++;
        end
        if (!ex_ready) checkOutput("issueReady", {31'd0, ex_ready}, 32'd1);
        cycle();
        ex_valid = 1'b0;
    endtask

    task automatic doStore(input string tag, input logic [31:0] addr, input logic [1:0] sz, input logic [1:0] sh,
                           input logic [31:0] d, input logic [3:0] expBe, input logic [31:0] expWdata);
        applyStimulus(OPC_STORE, 5'd3, addr, d, sz, sh, 1'b0, 1'b0);
        checkOutput({tag, ".req"},   {31'd0, dmemBus.dmem_req}, 32'd1);
        checkOutput({tag, ".we"},    {31'd0, dmemBus.dmem_we}, 32'd1);
        checkOutput({tag, ".addr"},  dmemBus.dmem_addr, addr);
        checkOutput({tag, ".be"},    {28'd0, dmemBus.dmem_be}, {28'd0, expBe});
        checkOutput({tag, ".wdata"}, dmemBus.dmem_wdata, expWdata);
        checkOutput({tag, ".stall"}, {31'd0, stall_req}, 32'd1);
        checkOutput({tag, ".rdMem"}, {27'd0, rd_MEM}, 32'd0);
        dmemBus.dmem_gnt = 1'b1;
        cycle();
        dmemBus.dmem_gnt = 1'b0;
        checkOutput({tag, ".stallDone"}, {31'd0, stall_req}, 32'd0);
        checkOutput({tag, ".reqDone"},   {31'd0, dmemBus.dmem_req}, 32'd0);
        checkOutput({tag, ".noWb"},      {31'd0, wb_valid}, 32'd0);
        checkOutput({tag, ".rdMemDone"}, {27'd0, rd_MEM}, 32'd0);
        cycle();
    endtask

    task automatic doLoad(input string tag, input logic [4:0] rd, input logic [1:0] sz, input logic [1:0] sh,
                          input logic uns, input logic [31:0] rdata, input int gntDelay, input logic sepRvalid,
                          input logic [3:0] expBe, input logic [31:0] expData);
        pushWb(rd, expData);
        applyStimulus(OPC_LOAD, rd, 32'h0000_0100, 32'd0, sz, sh, uns, 1'b0);
        checkOutput({tag, ".we"}, {31'd0, dmemBus.dmem_we}, 32'd0);
        checkOutput({tag, ".be"}, {28'd0, dmemBus.dmem_be}, {28'd0, expBe});
        for (int i = 0; i < gntDelay; i++) begin
            checkOutput({tag, ".reqWait"},   {31'd0, dmemBus.dmem_req}, 32'd1);
            checkOutput({tag, ".rdMemWait"}, {27'd0, rd_MEM}, 32'd0);
            cycle();
        end
        checkOutput({tag, ".req"}, {31'd0, dmemBus.dmem_req}, 32'd1);
        dmemBus.dmem_gnt = 1'b1;
        if (!sepRvalid) begin
            dmemBus.dmem_rvalid = 1'b1;
            dmemBus.dmem_rdata  = rdata;
        end
        cycle();
        dmemBus.dmem_gnt    = 1'b0;
        dmemBus.dmem_rvalid = 1'b0;
        if (sepRvalid) begin
            checkOutput({tag, ".stallWaitR"}, {31'd0, stall_req}, 32'd1);
            checkOutput({tag, ".rdMemWaitR"}, {27'd0, rd_MEM}, 32'd0);
            dmemBus.dmem_rvalid = 1'b1;
            dmemBus.dmem_rdata  = rdata;
            cycle();
            dmemBus.dmem_rvalid = 1'b0;
        end
        dmemBus.dmem_rdata = 32'd0;
        checkOutput({tag, ".rdMem"},  {27'd0, rd_MEM}, {27'd0, rd});
        checkOutput({tag, ".resMem"}, res_MEM, expData);
        checkOutput({tag, ".stall"},  {31'd0, stall_req}, 32'd0);
        cycle();
        checkOutput({tag, ".rdMemIdle"}, {27'd0, rd_MEM}, 32'd0);
    endtask

    // Scoreboard: every retirement or trap pulse must match the oldest expectation
    always @(negedge clk) begin
        if (wb_valid || trap_MEM) begin
            if (expQ.size() == 0) begin
                checkOutput("sbUnexpected", {30'd0, wb_valid, trap_MEM}, 32'd0);
            end else begin
                monE = expQ.pop_front();
                if (monE.isTrap) begin
                    checkOutput("sbTrap",     {31'd0, trap_MEM}, 32'd1);
                    checkOutput("sbCause",    {31'd0, trap_cause}, {31'd0, monE.cause});
                    checkOutput("sbTrapNoWb", {31'd0, wb_valid}, 32'd0);
                end else begin
                    checkOutput("sbWbValid", {31'd0, wb_valid}, 32'd1);
                    checkOutput("sbWbRd",    {27'd0, wb_rd}, {27'd0, monE.rd});
                    checkOutput("sbWbRes",   wb_res, monE.res);
                    checkOutput("sbWbNoTrap", {31'd0, trap_MEM}, 32'd0);
                end
            end
        end
    end

    // Hard stop in case the run wedges
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence
    initial begin
        int n;
        reset_n = 1'b0;
        ext_stall = 1'b0;
        ex_valid = 1'b0;
        ex_opcode = 7'd0;
        ex_rd = 5'd0;
        ex_res = 32'd0;
        ex_store_data = 32'd0;
        ex_ldsz = 2'd0;
        ex_ldshift = 2'd0;
        ex_ldunsigned = 1'b0;
        ex_trap = 1'b0;
        dmemBus.dmem_gnt = 1'b0;
        dmemBus.dmem_rvalid = 1'b0;
        dmemBus.dmem_rdata = 32'd0;
        repeat (3) cycle();

        checkOutput("rstReq",     {31'd0, dmemBus.dmem_req}, 32'd0);
        checkOutput("rstRdMem",   {27'd0, rd_MEM}, 32'd0);
        checkOutput("rstResMem",  res_MEM, 32'd0);
        checkOutput("rstWbValid", {31'd0, wb_valid}, 32'd0);
        checkOutput("rstWbRes",   wb_res, 32'd0);
        checkOutput("rstStall",   {31'd0, stall_req}, 32'd0);
        checkOutput("rstTrap",    {31'd0, trap_MEM}, 32'd0);
        checkOutput("rstReady",   {31'd0, ex_ready}, 32'd1);
        reset_n = 1'b1;
        cycle();

        $display("[TB] ALU forwarding and writeback");
        pushWb(5'd7, 32'h42);
        applyStimulus(OPC_ADD, 5'd7, 32'h42, 32'd0, LDSZ_WORD, 2'd0, 1'b0, 1'b0);
        checkOutput("aluRdMem",  {27'd0, rd_MEM}, 32'd7);
        checkOutput("aluResMem", res_MEM, 32'h42);
        checkOutput("aluStall",  {31'd0, stall_req}, 32'd0);
        checkOutput("aluNoReq",  {31'd0, dmemBus.dmem_req}, 32'd0);
        cycle();
        checkOutput("aluRdMemIdle", {27'd0, rd_MEM}, 32'd0);

        $display("[TB] back-to-back ALU and rd=0");
        pushWb(5'd8, 32'h111);
        pushWb(5'd9, 32'h222);
        applyStimulus(OPC_ADD, 5'd8, 32'h111, 32'd0, LDSZ_WORD, 2'd0, 1'b0, 1'b0);
        checkOutput("b2bRd1", {27'd0, rd_MEM}, 32'd8);
        applyStimulus(OPC_ADD, 5'd9, 32'h222, 32'd0, LDSZ_WORD, 2'd0, 1'b0, 1'b0);
        checkOutput("b2bRd2",  {27'd0, rd_MEM}, 32'd9);
        checkOutput("b2bRes2", res_MEM, 32'h222);
        applyStimulus(OPC_ADD, 5'd0, 32'h333, 32'd0, LDSZ_WORD, 2'd0, 1'b0, 1'b0);
        checkOutput("x0NoWb", {31'd0, wb_valid}, 32'd0);
        cycle();

        $display("[TB] stores");
        doStore("sw", 32'h100, LDSZ_WORD, 2'd0, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF);
        doStore("sb", 32'h104, LDSZ_BYTE, 2'd1, 32'h000000AB, 4'b0010, 32'hABABABAB);
        doStore("sh", 32'h108, LDSZ_HALF, 2'd2, 32'h1234ABCD, 4'b1100, 32'hABCDABCD);

        $display("[TB] loads");
        doLoad("lb",   5'd9,  LDSZ_BYTE, 2'd3, 1'b0, 32'h80FF1234, 3, 1'b0, 4'b1000, 32'hFFFFFF80);
        doLoad("lbu",  5'd9,  LDSZ_BYTE, 2'd3, 1'b1, 32'h80FF1234, 3, 1'b0, 4'b1000, 32'h00000080);
        doLoad("lh2",  5'd11, LDSZ_HALF, 2'd2, 1'b0, 32'h7FFF0000, 0, 1'b1, 4'b1100, 32'h00007FFF);
        doLoad("lh0",  5'd12, LDSZ_HALF, 2'd0, 1'b0, 32'h12348001, 1, 1'b1, 4'b0011, 32'hFFFF8001);
        doLoad("lhu0", 5'd13, LDSZ_HALF, 2'd0, 1'b1, 32'h12348001, 0, 1'b0, 4'b0011, 32'h00008001);
        doLoad("lw",   5'd14, LDSZ_WORD, 2'd0, 1'b0, 32'hCAFEF00D, 2, 1'b1, 4'b1111, 32'hCAFEF00D);
        doLoad("lb1",  5'd15, LDSZ_BYTE, 2'd1, 1'b0, 32'h00007F00, 0, 1'b0, 4'b0010, 32'h0000007F);

        $display("[TB] trap from EX");
        pushTrap(1'b0);
        applyStimulus(OPC_LOAD, 5'd4, 32'h101, 32'd0, LDSZ_HALF, 2'd1, 1'b0, 1'b1);
        checkOutput("exTrapNoReq", {31'd0, dmemBus.dmem_req}, 32'd0);
        checkOutput("exTrapRdMem", {27'd0, rd_MEM}, 32'd0);
        checkOutput("exTrapStall", {31'd0, stall_req}, 32'd0);
        cycle();
        checkOutput("exTrapPulse", {31'd0, trap_MEM}, 32'd0);

        $display("[TB] bus timeout");
        pushTrap(1'b1);
        applyStimulus(OPC_LOAD, 5'd10, 32'h300, 32'd0, LDSZ_WORD, 2'd0, 1'b0, 1'b0);
        n = 0;
        while (dmemBus.dmem_req && n < 20) begin
            n++;
            cycle();
        end
        checkOutput("toReqCycles", n, TIMEOUT);
        checkOutput("toTrap",      {31'd0, trap_MEM}, 32'd1);
        checkOutput("toCause",     {31'd0, trap_cause}, 32'd1);
        checkOutput("toStall",     {31'd0, stall_req}, 32'd0);
        checkOutput("toIdle",      {31'd0, ex_ready}, 32'd1);
        cycle();
        checkOutput("toPulse",     {31'd0, trap_MEM}, 32'd0);

        $display("[TB] ext_stall during REQ");
        applyStimulus(OPC_STORE, 5'd0, 32'h400, 32'h11223344, LDSZ_WORD, 2'd0, 1'b0, 1'b0);
        ext_stall = 1'b1;
        dmemBus.dmem_gnt = 1'b1;
        cycle();
        dmemBus.dmem_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("stlReq",   {31'd0, dmemBus.dmem_req}, 32'd1);
            checkOutput("stlAddr",  dmemBus.dmem_addr, 32'h400);
            checkOutput("stlStall", {31'd0, stall_req}, 32'd1);
            checkOutput("stlReady", {31'd0, ex_ready}, 32'd0);
            cycle();
        end
        ext_stall = 1'b0;
        cycle();
        checkOutput("stlDoneStall", {31'd0, stall_req}, 32'd0);
        checkOutput("stlDoneReq",   {31'd0, dmemBus.dmem_req}, 32'd0);
        checkOutput("stlDoneReady", {31'd0, ex_ready}, 32'd1);
        cycle();

        $display("[TB] reset during WAIT_R");
        applyStimulus(OPC_LOAD, 5'd6, 32'h500, 32'd0, LDSZ_WORD, 2'd0, 1'b0, 1'b0);
        dmemBus.dmem_gnt = 1'b1;
        cycle();
        dmemBus.dmem_gnt = 1'b0;
        checkOutput("rwWaitStall", {31'd0, stall_req}, 32'd1);
        reset_n = 1'b0;
        cycle();
        checkOutput("rwReq",   {31'd0, dmemBus.dmem_req}, 32'd0);
        checkOutput("rwStall", {31'd0, stall_req}, 32'd0);
        checkOutput("rwRdMem", {27'd0, rd_MEM}, 32'd0);
        checkOutput("rwWb",    {31'd0, wb_valid}, 32'd0);
        checkOutput("rwTrap",  {31'd0, trap_MEM}, 32'd0);
        checkOutput("rwRes",   res_MEM, 32'd0);
        reset_n = 1'b1;
        dmemBus.dmem_rvalid = 1'b1;
        dmemBus.dmem_rdata  = 32'h55;
        cycle();
        dmemBus.dmem_rvalid = 1'b0;
        checkOutput("rwLateWb",    {31'd0, wb_valid}, 32'd0);
        checkOutput("rwLateRdMem", {27'd0, rd_MEM}, 32'd0);
        cycle();
        checkOutput("rwLateWb2",   {31'd0, wb_valid}, 32'd0);

        repeat (2) cycle();
        checkOutput("sbEmpty", expQ.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
